uart_tx_fifo: RTL and testbench

Byte FIFO that sits directly upstream of the UART transmitter. It absorbs bursts of characters from the core's MMIO store path and drains them one byte per accepted handshake into the transmitter's `send_req` ready/valid port. It decouples CPU writes from the serial bit rate and exposes level/status for the MMIO status register.

---
 rtl/uart_tx_fifo_if.sv | 12 +
 rtl/uart_tx_fifo.sv | 67 ++++++
 tb/tb_uart_tx_fifo.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// Ready/valid byte-stream interface. TX is the master side (drives valid/data),
// RX is the slave side (drives ready).
interface rv_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport TX (output valid, output data, input ready);
  modport RX (input valid, input data, output ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the MMIO store path and the UART transmitter's send_req port.
// Show-ahead read, wrap-bit pointers, sticky overflow flag and synchronous flush.
module uart_tx_fifo #(
  parameter int DEPTH           = 16,
  parameter int ALMOST_FULL_LVL = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  rv_if.RX                         enq,
  rv_if.TX                         deq,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        push;
  logic        pop;

  assign empty       = (wr_ptr == rd_ptr);
  assign full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign count       = wr_ptr - rd_ptr;
  assign almost_full = int'(count) >= ALMOST_FULL_LVL;

  assign enq.ready = !full;
  assign deq.valid = !empty;
  assign deq.data  = mem[rd_ptr[AW-1:0]];

  assign push = enq.valid && enq.ready;
  assign pop  = deq.valid && deq.ready;

  // Flush wins over both handshakes: the write pointer snaps back to the read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= rd_ptr;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (enq.valid && full) begin
        ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr[AW-1:0]] <= enq.data;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: table-driven vectors with a data scoreboard,
// plus hand-written async-reset and end-to-end serial sequences.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int BIT   = 125_000_000 / 115200;

  typedef struct {
    logic       flush;
    logic       ev;
    logic [7:0] ed;
    logic       dr;
    int         exp_count;
    logic       exp_ovf;
  } vec_t;

  logic       clk;
  logic       clk_en;
  logic       rst_n;
  logic       flush;
  logic [4:0] count;
  logic       empty;
  logic       full;
  logic       almost_full;
  logic       ovf;
  logic       txd;

  int         n_vec;
  int         n_err;
  logic [7:0] sb [$];
  vec_t       vecs [$];
  logic [7:0] msg [3];

  rv_if #(.WIDTH(8)) enq_if ();
  rv_if #(.WIDTH(8)) deq_if ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ALMOST_FULL_LVL(AF)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enq         (enq_if),
    .deq         (deq_if),
    .flush       (flush),
    .count       (count),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .ovf         (ovf)
  );

  initial clk = 1'b0;
  always #5 if (clk_en) clk = ~clk;

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_output(input int exp_count, input logic exp_ovf);
    check("count", int'(count), exp_count);
    check("empty", int'(empty), int'(exp_count == 0));
    check("full", int'(full), int'(exp_count == DEPTH));
    check("almost_full", int'(almost_full), int'(exp_count >= AF));
    check("ovf", int'(ovf), int'(exp_ovf));
    check("deq_valid", int'(deq_if.valid), int'(exp_count != 0));
    check("enq_ready", int'(enq_if.ready), int'(exp_count != DEPTH));
  endtask

  // Drive one cycle at the falling edge; the scoreboard predicts handshakes from its own depth.
  task automatic apply_stimulus(input vec_t v);
    logic do_push;
    logic do_pop;
    @(negedge clk);
    flush        = v.flush;
    enq_if.valid = v.ev;
    enq_if.data  = v.ed;
    deq_if.ready = v.dr;
    #1;
    do_pop  = v.dr && (sb.size() > 0);
    do_push = v.ev && (sb.size() < DEPTH);
    if (do_pop && !v.flush) check("deq_data", int'(deq_if.data), int'(sb[0]));
    @(posedge clk);
    if (v.flush) begin
      sb.delete();
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (do_push) sb.push_back(v.ed);
    end
    #1;
    check_output(v.exp_count, v.exp_ovf);
  endtask

  task automatic tx_model();
    logic [7:0] b;
    logic [9:0] frame;
    int         waited;
    for (int k = 0; k < 3; k++) begin
      waited = 0;
      while (!deq_if.valid && waited < 100) begin
        @(posedge clk);
        #1;
        waited++;
      end
      if (!deq_if.valid) begin
        check("tx_wait_valid", 0, 1);
        return;
      end
      @(negedge clk);
      b            = deq_if.data;
      deq_if.ready = 1'b1;
      @(posedge clk);
      #1;
      deq_if.ready = 1'b0;
      if (k == 2) check("e2e_empty", int'(empty), 1);
      frame = {1'b1, b, 1'b0};
      for (int j = 0; j < 10; j++) begin
        txd = frame[j];
        repeat (BIT) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic rx_model();
    logic [7:0] r;
    int         idle;
    for (int k = 0; k < 3; k++) begin
      idle = 0;
      @(posedge clk);
      while (txd !== 1'b0 && idle < 20 * BIT) begin
        @(posedge clk);
        idle++;
      end
      if (txd !== 1'b0) begin
        check("rx_start_timeout", 1, 0);
        return;
      end
      if (k > 0) check("rx_gap_le_1bit", int'(idle <= BIT), 1);
      repeat (BIT / 2) @(posedge clk);
      check("rx_start_bit", int'(txd), 0);
      for (int j = 0; j < 8; j++) begin
        repeat (BIT) @(posedge clk);
        r[j] = txd;
      end
      repeat (BIT) @(posedge clk);
      check("rx_stop_bit", int'(txd), 1);
      check("rx_byte", int'(r), int'(msg[k]));
      repeat (BIT / 2) @(posedge clk);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    msg[0] = 8'h48;
    msg[1] = 8'h69;
    msg[2] = 8'h0A;

    // Fill to 16, one rejected write, drain in order.
    for (int i = 0; i < DEPTH; i++) vecs.push_back('{1'b0, 1'b1, 8'(i), 1'b0, i + 1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'hEE, 1'b0, DEPTH, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 8'hEF, 1'b1, DEPTH - 1, 1'b1});
    for (int i = 0; i < DEPTH - 1; i++) vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, DEPTH - 2 - i, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1});
    // Concurrent push/pop at a level of 5 across several pointer wraps.
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b0, 1'b1, 8'(8'hA0 + i), 1'b0, i + 1, 1'b1});
    for (int i = 0; i < 40; i++) vecs.push_back('{1'b0, 1'b1, 8'(8'hA5 + i), 1'b1, 5, 1'b1});
    // Reach 9 entries with ovf still set, then flush while 0x55 is offered.
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 1'b1, 8'(8'hD0 + i), 1'b0, 6 + i, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 8'h55, 1'b0, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0});

    clk_en       = 1'b0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    enq_if.valid = 1'b0;
    enq_if.data  = 8'h00;
    deq_if.ready = 1'b0;
    txd          = 1'b1;
    #20;
    $display("[TB] reset with clock stopped");
    check_output(0, 1'b0);
    rst_n = 1'b1;
    #3;
    clk_en = 1'b1;

    $display("[TB] applying %0d table vectors", vecs.size());
    foreach (vecs[i]) apply_stimulus(vecs[i]);

    $display("[TB] async reset mid-operation");
    for (int i = 0; i < 7; i++) apply_stimulus('{1'b0, 1'b1, 8'(8'h30 + i), 1'b0, i + 1, 1'b0});
    @(negedge clk);
    enq_if.valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("async_count", int'(count), 0);
    check("async_deq_valid", int'(deq_if.valid), 0);
    #1 rst_n = 1'b1;
    sb.delete();
    apply_stimulus('{1'b0, 1'b1, 8'hC1, 1'b0, 1, 1'b0});
    apply_stimulus('{1'b0, 1'b1, 8'hC2, 1'b0, 2, 1'b0});
    apply_stimulus('{1'b0, 1'b0, 8'h00, 1'b1, 1, 1'b0});
    apply_stimulus('{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b0});

    $display("[TB] end-to-end serial frames");
    @(negedge clk);
    deq_if.ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          enq_if.valid = 1'b1;
          enq_if.data  = msg[k];
        end
        @(negedge clk);
        enq_if.valid = 1'b0;
      end
      tx_model();
      rx_model();
    join
    #1;
    check("final_empty", int'(empty), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
